cp0_irq_stack: RTL
==================

// Module: cp0_irq_stack
// PURPOSE
//  Parametrised CP0 coprocessor: STATUS/MASK/EPC register bank plus NUM_IRQ-source interrupt controller.
//  Latches IRQ rising edges as pending and selects the lowest-index unmasked source.
//  Requests the pipeline via a REQ/ACK handshake; on ACK, pushes the EPC onto a DEPTH-entry stack so handlers can nest.
//  Sits beside the register file; read/written by MFC0/MTC0, popped by ERET.
// PARAMETERS
//  XLEN     32  register/PC width
//  NUM_IRQ  4   interrupt sources (1..16)
//  DEPTH    4   EPC stack entries / max nesting (>=1)
// PORTS
//  in_CLK     in   1            clock, all state on rising edge
//  in_RST     in   1            reset, synchronous, active-low
//  in_WE      in   1            MTC0 write enable
//  in_rW      in   3            write index
//  in_W       in   XLEN         write data
//  in_rA      in   3            read index
//  out_A      out  XLEN         read data, combinational
//  in_IRQ     in   NUM_IRQ      raw interrupt lines, level
//  out_REQ    out  1            interrupt request to pipeline
//  out_ID     out  clog2(NUM_IRQ) (min 1)  selected source while out_REQ
//  in_ACK     in   1            pipeline takes interrupt this cycle
//  in_EPC     in   XLEN         PC to save, valid with in_ACK
//  in_ERET    in   1            return from handler
//  out_IE     out  1            STATUS[0]
//  out_INM    out  NUM_IRQ      MASK[NUM_IRQ-1:0], 1 = masked
//  out_EPC    out  XLEN         top of EPC stack, 0 when empty
//  out_DEPTH  out  clog2(DEPTH+1)  live stack entries
// BEHAVIOUR
//  Register map: 0 STATUS (bit0 IE, rest read 0); 1 MASK; 2 EPC (top of stack); 3 CAUSE; 4 DEPTH (read-only);
//  5-7 read 0, writes ignored.
//  Reset (in_RST==0 at clock edge): IE=1, MASK=0, all stack entries 0, depth=0, pending=0, IRQ history=0.
//  Resulting outputs: out_REQ=0, out_EPC=0, out_DEPTH=0. Reset overrides every other input, including mid-handler.
//  Edge detect: pending[i] sets on in_IRQ[i] rising edge (registered prev sample); 1-cycle latency to pending.
//  eligible = pending & ~MASK.
//  out_REQ = IE & |eligible & (depth<DEPTH); out_ID = lowest set index of eligible. Both combinational from state.
//  ACK honoured only when out_REQ=1 and in_ERET=0. It pushes in_EPC, depth+1, clears pending[out_ID], IE<=0.
//  ACK while out_REQ=0 is ignored.
//  ERET with depth>0: pop (top entry zeroed), depth-1, IE<=1. ERET with depth==0: no pop, IE<=1.
//  ERET and ACK in same cycle: ERET wins, ACK ignored, pending untouched.
//  New rising edge on the source being cleared by ACK in the same cycle: set wins, bit stays pending.
//  Stack full (depth==DEPTH): out_REQ forced 0, pending keeps accumulating; no overflow possible.
//  MTC0 to 0 writes IE=in_W[0]; to 1 writes MASK; to 2 overwrites top entry, ignored when depth==0.
//  Same-cycle MTC0 and ACK/ERET: ACK/ERET update of IE/EPC wins; a MASK write still applies.
//  Software re-enabling IE inside a handler permits nesting; the new request is evaluated the following cycle.
// CONFIGURATION
//  CP0_CAUSE_EN defined: index 3 reads {8'b0, last_id[7:0], pending[15:0]} (widths zero-padded, XLEN>=32).
//  last_id = ID of most recent honoured ACK, reset 0. CAUSE is read-only.
//  CP0_CAUSE_EN undefined: no last_id register; index 3 reads 0; all other behaviour identical.
// TESTING
//  Reset, then read idx 0/1/2/4 -> 1/0/0/0; out_REQ=0.
//  IRQ[2] rise, IRQ[1] rise next cycle -> REQ=1, ID=2, then ID=1 once pending[1] set.
//   ACK EPC=0x100 -> out_EPC=0x100, IE=0, DEPTH=1, REQ=0.
//  MASK=0x2 with IRQ[1] pending -> REQ=0. MASK=0 -> REQ=1, ID=1 next cycle.
//  Nest to DEPTH=4: EPCs 0x10,0x20,0x30,0x40 with IE set between each.
//   IRQ pending at DEPTH=4 -> REQ=0. Four ERETs -> out_EPC 0x30,0x20,0x10,0; fifth ERET -> DEPTH stays 0, IE=1.
//  ERET+ACK same cycle -> DEPTH-1, pending bit kept. in_RST low while DEPTH=2 -> all reset values next edge.
//  With CP0_CAUSE_EN: ACK on ID 3, IRQ[0] pending -> idx 3 reads 0x00030001. Without: idx 3 reads 0.

Source files
------------

// File: rtl/cp0_irq_stack.sv
// cp0_irq_stack: CP0 STATUS/MASK/EPC bank with a nesting interrupt controller.
// Rising edges on in_IRQ latch as pending. The lowest-index unmasked pending source is
// requested from the pipeline. On ACK the EPC is pushed onto a DEPTH-entry stack, and ERET
// pops it. Optional feature macro: CP0_CAUSE_EN enables a read-only CAUSE register at
// index 3, holding {last_id, pending}.
module cp0_irq_stack #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_IRQ = 4,
    parameter int unsigned DEPTH   = 4,
    localparam int unsigned IdW    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    localparam int unsigned DepW   = $clog2(DEPTH + 1)
) (
    input  logic               in_CLK,
    input  logic               in_RST,
    input  logic               in_WE,
    input  logic [2:0]         in_rW,
    input  logic [XLEN-1:0]    in_W,
    input  logic [2:0]         in_rA,
    output logic [XLEN-1:0]    out_A,
    input  logic [NUM_IRQ-1:0] in_IRQ,
    output logic               out_REQ,
    output logic [IdW-1:0]     out_ID,
    input  logic               in_ACK,
    input  logic [XLEN-1:0]    in_EPC,
    input  logic               in_ERET,
    output logic               out_IE,
    output logic [NUM_IRQ-1:0] out_INM,
    output logic [XLEN-1:0]    out_EPC,
    output logic [DepW-1:0]    out_DEPTH
);

    logic               ie_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [XLEN-1:0]    stack_q [DEPTH];   // entry 0 is the top of stack
    logic [DepW-1:0]    depth_q;

    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] sel_onehot;
    logic [IdW-1:0]     sel_id;
    logic               req;
    logic               ack_ok;
    logic               pop;
    logic               wr_status;
    logic               wr_mask;
    logic               wr_epc;
    logic [XLEN-1:0]    cause;

    assign eligible  = pending_q & ~mask_q;
    assign req       = ie_q & (|eligible) & (depth_q < DepW'(DEPTH));
    assign ack_ok    = in_ACK & req & ~in_ERET;
    assign pop       = in_ERET & (depth_q != '0);
    assign wr_status = in_WE & (in_rW == 3'd0);
    assign wr_mask   = in_WE & (in_rW == 3'd1);
    assign wr_epc    = in_WE & (in_rW == 3'd2) & (depth_q != '0);

    // Priority encoder: lowest-index eligible source, plus its one-hot clear vector
    always_comb begin
        sel_id     = '0;
        sel_onehot = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (eligible[i]) sel_id = IdW'(i);
        end
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            sel_onehot[i] = (sel_id == IdW'(i));
        end
    end

    // Edge detect and pending latch; a new edge beats a same-cycle ACK clear
    always_ff @(posedge in_CLK) begin
        if (!in_RST) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
        end else begin
            irq_prev_q <= in_IRQ;
            pending_q  <= (pending_q & ~(ack_ok ? sel_onehot : '0)) | (in_IRQ & ~irq_prev_q);
        end
    end

    // STATUS.IE and MASK; ERET/ACK take priority over a software IE write
    always_ff @(posedge in_CLK) begin
        if (!in_RST) begin
            ie_q   <= 1'b1;
            mask_q <= '0;
        end else begin
            if (in_ERET)        ie_q <= 1'b1;
            else if (ack_ok)    ie_q <= 1'b0;
            else if (wr_status) ie_q <= in_W[0];
            if (wr_mask) mask_q <= in_W[NUM_IRQ-1:0];
        end
    end

    // EPC stack as a shift register, so vacated entries read back as zero
    always_ff @(posedge in_CLK) begin
        if (!in_RST) begin
            for (int i = 0; i < int'(DEPTH); i++) stack_q[i] <= '0;
            depth_q <= '0;
        end else if (pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) stack_q[i] <= stack_q[i+1];
            stack_q[DEPTH-1] <= '0;
            depth_q          <= depth_q - DepW'(1);
        end else if (ack_ok) begin
            for (int i = 1; i < int'(DEPTH); i++) stack_q[i] <= stack_q[i-1];
            stack_q[0] <= in_EPC;
            depth_q    <= depth_q + DepW'(1);
        end else if (wr_epc) begin
            stack_q[0] <= in_W;
        end
    end

`ifdef CP0_CAUSE_EN
    logic [IdW-1:0] last_id_q;

    // ID of the most recently honoured ACK, exposed through CAUSE
    always_ff @(posedge in_CLK) begin
        if (!in_RST)     last_id_q <= '0;
        else if (ack_ok) last_id_q <= sel_id;
    end

    assign cause = XLEN'({8'b0, 8'(last_id_q), 16'(pending_q)});
`else
    assign cause = '0;
`endif

    // MFC0 read mux
    always_comb begin
        out_A = '0;
        case (in_rA)
            3'd0:    out_A = XLEN'(ie_q);
            3'd1:    out_A = XLEN'(mask_q);
            3'd2:    out_A = stack_q[0];
            3'd3:    out_A = cause;
            3'd4:    out_A = XLEN'(depth_q);
            default: out_A = '0;
        endcase
    end

    assign out_REQ   = req;
    assign out_ID    = sel_id;
    assign out_IE    = ie_q;
    assign out_INM   = mask_q;
    assign out_EPC   = stack_q[0];
    assign out_DEPTH = depth_q;

endmodule
